a2d_sweep_seq: RTL and testbench
================================

A2D_SWEEP_SEQ -- requirements
Module: a2d_sweep_seq

Interface
REQ-001 The block SHALL have parameter CH0, default 3'd0, meaning the A2D channel for lft_ld.
REQ-002 The block SHALL have parameter CH1, default 3'd4, meaning the A2D channel for rght_ld.
REQ-003 The block SHALL have parameter CH2, default 3'd5, meaning the A2D channel for steer_pot.
REQ-004 The block SHALL have parameter CH3, default 3'd6, meaning the A2D channel for batt.
REQ-005 The block SHALL have parameter TMO, default 12'd2048, meaning the clk cycles to wait for done before aborting.
REQ-006 The block SHALL have one clock and an asynchronous, active-low reset: ports clk and rst_n.
REQ-007 clk  input  1  system clock, all state updates on its rising edge.
REQ-008 rst_n  input  1  asynchronous active-low reset.
REQ-009 nxt  input  1  one-cycle pulse that starts a four-channel sweep.
REQ-010 wrt  output  1  one-cycle pulse to the SPI master that starts a transaction.
REQ-011 cmd  output  16  SPI command, always {2'b00, chnl[2:0], 11'h000}.
REQ-012 done  input  1  SPI master end-of-transaction indication.
REQ-013 rd_data  input  16  SPI master read data, valid in the cycle done is high.
REQ-014 lft_ld, rght_ld, steer_pot, batt  output  12 each  last captured conversion per channel.
REQ-015 busy  output  1  high from the cycle after an accepted nxt until the sweep ends.
REQ-016 swp_rdy  output  1  one-cycle pulse when all four results are updated.
REQ-017 err  output  1  sticky timeout flag, cleared only by the next accepted nxt or by reset.

Function
REQ-018 The FSM SHALL have states IDLE, SEND1, WAIT1, SEND2, WAIT2 and NEXT.
REQ-019 In IDLE, nxt SHALL be accepted: index idx=0, err cleared, state SEND1.
REQ-020 nxt while busy SHALL be ignored, with no queuing.
REQ-021 SEND1 SHALL pulse wrt for 1 cycle with cmd for channel CH[idx], then go to WAIT1; wrt is therefore high the cycle after nxt.
REQ-022 In WAIT1, done SHALL move the FSM to SEND2, and rd_data SHALL be discarded.
REQ-023 SEND2 SHALL be entered one cycle after done (one idle gap) and SHALL pulse wrt with the identical cmd, then go to WAIT2.
REQ-024 In WAIT2, done SHALL capture rd_data[11:0] into the output selected by idx in that same cycle, then go to NEXT.
REQ-025 NEXT SHALL set idx to idx+1 (2-bit) and go to SEND1 if idx<3; at idx==3 it SHALL pulse swp_rdy and go to IDLE.
REQ-026 cmd SHALL hold its value from SEND1 until the following SEND1 or IDLE, so it is stable throughout each transaction.
REQ-027 done outside WAIT1/WAIT2 SHALL be ignored.
REQ-028 A timeout counter SHALL clear on entry to WAIT1/WAIT2 and increment each cycle in those states.
REQ-029 When the counter reaches TMO-1 without done, err SHALL set and the FSM SHALL go to IDLE; outputs already updated keep their values, no swp_rdy.
REQ-030 done in the same cycle as the timeout SHALL take priority: capture/advance, no err.
REQ-031 The nominal sweep SHALL be 8 transactions; there SHALL be no back-to-back wrt pulses.

Reset
REQ-032 rst_n low SHALL force IDLE, idx=0, counter=0, wrt=0, cmd=16'h0000, busy=0, swp_rdy=0, err=0, and all four 12-bit outputs=12'h000.
REQ-033 Reset mid-sweep SHALL abort immediately; after release, the block SHALL wait for a new nxt and SHALL NOT issue wrt spontaneously.

Structure
REQ-034 A shared package SHALL hold the state enum, the cmd field positions and the default channel constants.
REQ-035 The timeout counter SHALL be the one sub-module, tmo_cnt (clear, enable, terminal-count output).
REQ-036 Per-channel storage SHALL be four 12-bit registers written by an idx decode.

Verification
REQ-037 nxt with an SPI slave model returning 16'h0ABC -> cmd sequence 0000,0000,2000,2000,2800,2800,3000,3000; all outputs = 12'hABC; one swp_rdy pulse.
REQ-038 Slave returns per-channel 16'hF123/0456/0789/0FFF -> outputs 123/456/789/FFF (upper nibble dropped).
REQ-039 nxt pulsed again in the 3rd transaction -> ignored; exactly 8 wrt pulses, one swp_rdy.
REQ-040 Slave never asserts done with TMO=16 -> err=1 after 16 WAIT1 cycles, busy=0, outputs unchanged; the next nxt clears err.
REQ-041 rst_n low during WAIT2 of channel 2 -> all outputs 0 immediately, and no wrt for 100 cycles after release.
REQ-042 Spurious done in IDLE -> no state change, no capture.

Source files
------------

// File: rtl/a2d_sweep_seq_pkg.sv
// Shared types and constants for the A2D channel sweep sequencer.
package a2d_sweep_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEND1 = 3'd1,
    WAIT1 = 3'd2,
    SEND2 = 3'd3,
    WAIT2 = 3'd4,
    NEXT  = 3'd5
  } state_e;

  localparam int CMD_W      = 16;
  localparam int CMD_CH_LSB = 11;
  localparam int CH_W       = 3;
  localparam int RES_W      = 12;
  localparam int TMO_W      = 12;

  localparam logic [CH_W-1:0]  CH0_DEF = 3'd0;
  localparam logic [CH_W-1:0]  CH1_DEF = 3'd4;
  localparam logic [CH_W-1:0]  CH2_DEF = 3'd5;
  localparam logic [CH_W-1:0]  CH3_DEF = 3'd6;
  localparam logic [TMO_W-1:0] TMO_DEF = 12'd2048;

  function automatic logic [CMD_W-1:0] chan_cmd(input logic [CH_W-1:0] ch);
    logic [CMD_W-1:0] c;
    c = '0;
    c[CMD_CH_LSB +: CH_W] = ch;
    return c;
  endfunction

endpackage

// File: rtl/a2d_sweep_seq_tmo_cnt.sv
// Wait-state timeout counter: cleared before each wait, counts while enabled,
// holds at the terminal count TMO-1.
module a2d_sweep_seq_tmo_cnt
  import a2d_sweep_seq_pkg::*;
#(
  parameter logic [TMO_W-1:0] TMO = TMO_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [TMO_W-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == TMO - 12'd1);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && !tc_o)
      cnt_d = cnt_q + 12'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/a2d_sweep_seq.sv
// Sweeps four A2D channels over SPI; each channel is read twice and only the
// second response is kept.
//   state | meaning
//   IDLE  | waiting for nxt
//   SEND1 | wrt pulse, first (discarded) transaction
//   WAIT1 | wait for done of the first transaction
//   SEND2 | wrt pulse, same cmd, result transaction
//   WAIT2 | wait for done, capture rd_data[11:0]
//   NEXT  | advance channel index or finish sweep
module a2d_sweep_seq
  import a2d_sweep_seq_pkg::*;
#(
  parameter logic [CH_W-1:0]  CH0 = CH0_DEF,
  parameter logic [CH_W-1:0]  CH1 = CH1_DEF,
  parameter logic [CH_W-1:0]  CH2 = CH2_DEF,
  parameter logic [CH_W-1:0]  CH3 = CH3_DEF,
  parameter logic [TMO_W-1:0] TMO = TMO_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             nxt,
  output logic             wrt,
  output logic [CMD_W-1:0] cmd,
  input  logic             done,
  input  logic [CMD_W-1:0] rd_data,
  output logic [RES_W-1:0] lft_ld,
  output logic [RES_W-1:0] rght_ld,
  output logic [RES_W-1:0] steer_pot,
  output logic [RES_W-1:0] batt,
  output logic             busy,
  output logic             swp_rdy,
  output logic             err
);

  state_e           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [CMD_W-1:0] cmd_q, cmd_d;
  logic             err_q, err_d;
  logic [RES_W-1:0] res_q [4];
  logic             cap, tmo_clr, tmo_en, tmo_tc;
  logic             unused_rd_hi;

  assign unused_rd_hi = ^rd_data[CMD_W-1:RES_W];

  function automatic logic [CH_W-1:0] chan_of(input logic [1:0] i);
    case (i)
      2'd0:    return CH0;
      2'd1:    return CH1;
      2'd2:    return CH2;
      default: return CH3;
    endcase
  endfunction

  a2d_sweep_seq_tmo_cnt #(.TMO(TMO)) tmo_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (tmo_clr),
    .en_i  (tmo_en),
    .tc_o  (tmo_tc)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cmd_d   = cmd_q;
    err_d   = err_q;
    cap     = 1'b0;
    tmo_clr = 1'b0;
    tmo_en  = 1'b0;
    case (state_q)
      IDLE: if (nxt) begin
        idx_d   = 2'd0;
        err_d   = 1'b0;
        cmd_d   = chan_cmd(chan_of(2'd0));
        state_d = SEND1;
      end
      SEND1: begin
        tmo_clr = 1'b1;
        state_d = WAIT1;
      end
      WAIT1: begin
        tmo_en = 1'b1;
        // done wins over a timeout landing in the same cycle
        if (done)        state_d = SEND2;
        else if (tmo_tc) begin err_d = 1'b1; state_d = IDLE; end
      end
      SEND2: begin
        tmo_clr = 1'b1;
        state_d = WAIT2;
      end
      WAIT2: begin
        tmo_en = 1'b1;
        if (done)        begin cap = 1'b1; state_d = NEXT; end
        else if (tmo_tc) begin err_d = 1'b1; state_d = IDLE; end
      end
      NEXT: begin
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) state_d = IDLE;
        else begin
          cmd_d   = chan_cmd(chan_of(idx_q + 2'd1));
          state_d = SEND1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      cmd_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cmd_q   <= cmd_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) res_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (cap && (idx_q == 2'(i))) res_q[i] <= rd_data[RES_W-1:0];
    end
  end

  assign wrt       = (state_q == SEND1) || (state_q == SEND2);
  assign cmd       = cmd_q;
  assign busy      = (state_q != IDLE);
  assign swp_rdy   = (state_q == NEXT) && (idx_q == 2'd3);
  assign err       = err_q;
  assign lft_ld    = res_q[0];
  assign rght_ld   = res_q[1];
  assign steer_pot = res_q[2];
  assign batt      = res_q[3];

endmodule

// File: tb/tb_a2d_sweep_seq.sv
// Randomized bench for a2d_sweep_seq with an SPI slave model and a sweep-level
// reference (channel list, expected cmd sequence, expected captured values).
module tb_a2d_sweep_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        nxt = 1'b0;
  logic        wrt, busy, swp_rdy, err;
  logic [15:0] cmd;
  logic [11:0] lft_ld, rght_ld, steer_pot, batt;
  logic        done;
  logic [15:0] rd_data;

  logic        spur_done = 1'b0;
  logic        sl_done = 1'b0;
  logic [15:0] sl_rd = 16'h0;

  assign done    = sl_done | spur_done;
  assign rd_data = spur_done ? 16'hDEAD : sl_rd;

  a2d_sweep_seq #(.TMO(12'd16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .nxt       (nxt),
    .wrt       (wrt),
    .cmd       (cmd),
    .done      (done),
    .rd_data   (rd_data),
    .lft_ld    (lft_ld),
    .rght_ld   (rght_ld),
    .steer_pot (steer_pot),
    .batt      (batt),
    .busy      (busy),
    .swp_rdy   (swp_rdy),
    .err       (err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // sweep order and expected captures
  logic [2:0]  chans [4] = '{3'd0, 3'd4, 3'd5, 3'd6};
  logic [11:0] exp_out [4] = '{12'h0, 12'h0, 12'h0, 12'h0};
  logic [15:0] resp [8];

  function automatic logic [15:0] exp_cmd(input logic [2:0] ch);
    return {2'b00, ch, 11'h000};
  endfunction

  // SPI slave: answers each wrt after a delay; odd transactions carry the result
  bit          mute = 1'b0;
  int          fixed_dly = 0;
  int          cd = 0;
  int          sl_n = 0;
  logic [15:0] pend = 16'h0;

  always @(negedge clk) begin
    sl_done = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        sl_done = 1'b1;
        sl_rd   = pend;
      end
    end
    if (wrt && !mute) begin
      cd   = (fixed_dly > 0) ? fixed_dly : int'($urandom_range(1, 10));
      pend = (sl_n % 2 == 1) ? resp[cmd[13:11]] : 16'($urandom);
      sl_n++;
    end
  end

  int          wrt_cnt = 0, swp_cnt = 0, b2b = 0;
  logic [15:0] cmd_log [$];
  logic        prev_wrt = 1'b0;

  always @(negedge clk) begin
    if (wrt) begin
      wrt_cnt++;
      cmd_log.push_back(cmd);
      if (prev_wrt) b2b++;
    end
    if (swp_rdy) swp_cnt++;
    prev_wrt = wrt;
  end

  task automatic clr_mon();
    wrt_cnt = 0;
    swp_cnt = 0;
    b2b     = 0;
    cmd_log.delete();
    sl_n    = 0;
  endtask

  task automatic pulse_nxt();
    @(negedge clk) nxt = 1'b1;
    @(negedge clk) nxt = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_idle_in_time"}, 32'(n < 3000), 32'd1);
  endtask

  task automatic wait_wrts(input string tag, input int target);
    int n = 0;
    while (wrt_cnt < target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_wrt_in_time"}, 32'(n < 3000), 32'd1);
  endtask

  task automatic check_outs(input string tag);
    chk({tag, "_lft"},   32'(lft_ld),    32'(exp_out[0]));
    chk({tag, "_rght"},  32'(rght_ld),   32'(exp_out[1]));
    chk({tag, "_steer"}, 32'(steer_pot), 32'(exp_out[2]));
    chk({tag, "_batt"},  32'(batt),      32'(exp_out[3]));
  endtask

  task automatic check_sweep(input string tag);
    chk({tag, "_ncmd"}, 32'(cmd_log.size()), 32'd8);
    for (int i = 0; i < 8 && i < cmd_log.size(); i++)
      chk($sformatf("%s_cmd%0d", tag, i), 32'(cmd_log[i]), 32'(exp_cmd(chans[i/2])));
    for (int i = 0; i < 4; i++) exp_out[i] = resp[chans[i]][11:0];
    check_outs(tag);
    chk({tag, "_swp"}, 32'(swp_cnt), 32'd1);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_b2b"}, 32'(b2b), 32'd0);
  endtask

  task automatic do_sweep(input string tag);
    clr_mon();
    pulse_nxt();
    wait_idle(tag);
    check_sweep(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) resp[i] = 16'h0;
    repeat (3) @(negedge clk);
    chk("rst_wrt", 32'(wrt), 32'd0);
    chk("rst_cmd", 32'(cmd), 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_swp", 32'(swp_rdy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    check_outs("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // stray done while idle
    clr_mon();
    spur_done = 1'b1;
    @(negedge clk) spur_done = 1'b0;
    @(negedge clk);
    chk("spur_busy", 32'(busy), 32'd0);
    chk("spur_wrt", 32'(wrt_cnt), 32'd0);
    check_outs("spur");

    for (int i = 0; i < 8; i++) resp[i] = 16'h0ABC;
    do_sweep("abc");

    resp[0] = 16'hF123; resp[4] = 16'h0456; resp[5] = 16'h0789; resp[6] = 16'h0FFF;
    do_sweep("nib");

    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 8; i++) resp[i] = 16'($urandom);
      do_sweep($sformatf("rnd%0d", k));
    end

    // nxt during the third transaction is dropped
    for (int i = 0; i < 8; i++) resp[i] = 16'($urandom);
    clr_mon();
    pulse_nxt();
    wait_wrts("ign", 3);
    pulse_nxt();
    wait_idle("ign");
    check_sweep("ign");
    chk("ign_wrts", 32'(wrt_cnt), 32'd8);

    // done exactly on the timeout cycle is still accepted
    fixed_dly = 16;
    for (int i = 0; i < 8; i++) resp[i] = 16'($urandom);
    do_sweep("d16");

    // one cycle later it is too late
    fixed_dly = 17;
    clr_mon();
    pulse_nxt();
    wait_idle("d17");
    chk("d17_err", 32'(err), 32'd1);
    chk("d17_swp", 32'(swp_cnt), 32'd0);
    chk("d17_wrts", 32'(wrt_cnt), 32'd1);
    check_outs("d17");
    repeat (4) @(negedge clk);

    // silent slave: abort after 16 wait cycles
    fixed_dly = 0;
    mute = 1'b1;
    clr_mon();
    pulse_nxt();
    chk("mute_wrt", 32'(wrt), 32'd1);
    repeat (16) @(negedge clk);
    chk("mute_busy_pre", 32'(busy), 32'd1);
    chk("mute_err_pre", 32'(err), 32'd0);
    @(negedge clk);
    chk("mute_busy", 32'(busy), 32'd0);
    chk("mute_err", 32'(err), 32'd1);
    chk("mute_wrts", 32'(wrt_cnt), 32'd1);
    chk("mute_swp", 32'(swp_cnt), 32'd0);
    check_outs("mute");

    mute = 1'b0;
    for (int i = 0; i < 8; i++) resp[i] = 16'($urandom);
    clr_mon();
    pulse_nxt();
    chk("reclr_err", 32'(err), 32'd0);
    wait_idle("reclr");
    check_sweep("reclr");

    // reset during WAIT2 of the third channel
    fixed_dly = 8;
    for (int i = 0; i < 8; i++) resp[i] = 16'($urandom);
    clr_mon();
    pulse_nxt();
    wait_wrts("rmid", 6);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) exp_out[i] = 12'h0;
    check_outs("rmid");
    chk("rmid_busy", 32'(busy), 32'd0);
    chk("rmid_cmd", 32'(cmd), 32'h0);
    chk("rmid_wrt", 32'(wrt), 32'd0);
    cd = 0;
    @(negedge clk) rst_n = 1'b1;
    clr_mon();
    repeat (100) @(negedge clk);
    chk("rmid_nowrt", 32'(wrt_cnt), 32'd0);
    chk("rmid_idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
